// File: rtl/posit_mul_arbiter.sv
// Round-robin scheduler sharing one posit_mul between NUM_REQ requesters.
// Completion is taken on the rising edge of mul_done; a watchdog flushes a hung multiplier.
module posit_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_result,
   output logic                  rsp_nar,
   output logic                  rsp_zero,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic                  mul_start,
   output logic [31:0]           mul_a,
   output logic [31:0]           mul_b,
   output logic                  mul_rst_n,
   input  logic [31:0]           mul_result,
   input  logic                  mul_done,
   input  logic                  mul_nar,
   input  logic                  mul_zero
);
   localparam int          PW       = $clog2(NUM_REQ);
   localparam logic [9:0]  CNT_LAST = 10'(TIMEOUT - 1);
   localparam logic [31:0] NAR      = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      FLUSH = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       win_q, win_d;
   logic [9:0]          cnt_q, cnt_d;
   logic                flush_q, flush_d;
   logic                mul_done_q;
   logic [31:0]         mul_a_q, mul_a_d;
   logic [31:0]         mul_b_q, mul_b_d;
   logic                mul_start_q, mul_start_d;
   logic                mul_rst_n_q, mul_rst_n_d;
   logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_result_q, rsp_result_d;
   logic                rsp_nar_q, rsp_nar_d;
   logic                rsp_zero_q, rsp_zero_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                busy_q;
   logic                found;
   logic [PW-1:0]       pick;
   logic [PW:0]         idx;
   logic                done_edge;

   assign done_edge = mul_done & ~mul_done_q;

   // Search upward from ptr_q, wrapping modulo NUM_REQ, for the first valid requester.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, ptr_q} + (PW+1)'(i);
         if (idx >= (PW+1)'(NUM_REQ)) begin
            idx = idx - (PW+1)'(NUM_REQ);
         end else begin
            idx = idx;
         end
         if (!found && req_valid[idx[PW-1:0]]) begin
            found = 1'b1;
            pick  = idx[PW-1:0];
         end else begin
            found = found;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      win_d         = win_q;
      cnt_d         = cnt_q;
      flush_d       = 1'b0;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      mul_start_d   = 1'b0;
      mul_rst_n_d   = 1'b1;
      req_ready_d   = '0;
      rsp_valid_d   = '0;
      rsp_result_d  = rsp_result_q;
      rsp_nar_d     = rsp_nar_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               mul_a_d           = req_a[{pick, 5'd0} +: 32];
               mul_b_d           = req_b[{pick, 5'd0} +: 32];
               win_d             = pick;
               ptr_d             = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + PW'(1);
               req_ready_d[pick] = 1'b1;
               mul_start_d       = 1'b1;
               state_d           = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 10'd1;
            // A completion edge in the final watchdog cycle still counts as a normal result.
            if (done_edge) begin
               rsp_result_d       = mul_result;
               rsp_nar_d          = mul_nar;
               rsp_zero_d         = mul_zero;
               rsp_timeout_d      = 1'b0;
               rsp_valid_d[win_q] = 1'b1;
               state_d            = RESP;
            end else if (cnt_q == CNT_LAST) begin
               mul_rst_n_d = 1'b0;
               state_d     = FLUSH;
            end else begin
               state_d = WAIT;
            end
         end
         FLUSH: begin
            if (flush_q) begin
               rsp_result_d       = NAR;
               rsp_nar_d          = 1'b1;
               rsp_zero_d         = 1'b0;
               rsp_timeout_d      = 1'b1;
               rsp_valid_d[win_q] = 1'b1;
               state_d            = RESP;
            end else begin
               mul_rst_n_d = 1'b0;
               flush_d     = 1'b1;
               state_d     = FLUSH;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         win_q         <= '0;
         cnt_q         <= '0;
         flush_q       <= 1'b0;
         mul_done_q    <= 1'b0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         mul_start_q   <= 1'b0;
         mul_rst_n_q   <= 1'b0;
         req_ready_q   <= '0;
         rsp_valid_q   <= '0;
         rsp_result_q  <= '0;
         rsp_nar_q     <= 1'b0;
         rsp_zero_q    <= 1'b0;
         rsp_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         win_q         <= win_d;
         cnt_q         <= cnt_d;
         flush_q       <= flush_d;
         mul_done_q    <= mul_done;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         mul_start_q   <= mul_start_d;
         mul_rst_n_q   <= mul_rst_n_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_nar_q     <= rsp_nar_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_timeout_q <= rsp_timeout_d;
         busy_q        <= (state_d != IDLE);
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_nar     = rsp_nar_q;
   assign rsp_zero    = rsp_zero_q;
   assign rsp_timeout = rsp_timeout_q;
   assign busy        = busy_q;
   assign mul_start   = mul_start_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign mul_rst_n   = mul_rst_n_q;

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Directed bench for posit_mul_arbiter against a behavioural multiplier mock with
// normal, hung and level-held completion modes; responses are checked from a scoreboard.
module tb_posit_mul_arbiter;
   localparam int NR = 4;
   localparam int TO = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic [NR-1:0]       req_valid;
   logic [32*NR-1:0]    req_a;
   logic [32*NR-1:0]    req_b;
   logic [NR-1:0]       req_ready;
   logic [NR-1:0]       rsp_valid;
   logic [31:0]         rsp_result;
   logic                rsp_nar;
   logic                rsp_zero;
   logic                rsp_timeout;
   logic                busy;
   logic                mul_start;
   logic [31:0]         mul_a;
   logic [31:0]         mul_b;
   logic                mul_rst_n;
   logic [31:0]         mul_result = 32'h0;
   logic                mul_done   = 1'b0;
   logic                mul_nar    = 1'b0;
   logic                mul_zero   = 1'b0;

   always #5 clk = ~clk;

   posit_mul_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_nar(rsp_nar), .rsp_zero(rsp_zero), .rsp_timeout(rsp_timeout), .busy(busy),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_rst_n(mul_rst_n),
      .mul_result(mul_result), .mul_done(mul_done), .mul_nar(mul_nar), .mul_zero(mul_zero)
   );

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic        nar;
      logic        zero;
      logic        to;
   } exp_t;

   exp_t sq[$];
   int   gq[$];
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   rsp_cnt   = 0;
   int   grant_cyc = 0;
   int   rsp_cyc   = 0;
   int   nrst_low  = 0;
   int   mock_mode = 0;
   int   mock_lat  = 3;
   logic        m_act = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_a   = 32'h0;
   logic [31:0] m_b   = 32'h0;

   // Mock result: 1.0*1.0 gives 1.0, and chosen operands reach the zero and NaR encodings.
   function automatic logic [31:0] mock_mul(input logic [31:0] a, input logic [31:0] b);
      return a ^ b ^ 32'h4000_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int i, input logic to);
      exp_t        e;
      logic [31:0] r;
      r      = mock_mul(req_a[32*i +: 32], req_b[32*i +: 32]);
      e.idx  = i;
      e.res  = to ? 32'h8000_0000 : r;
      e.nar  = to ? 1'b1 : (r == 32'h8000_0000);
      e.zero = to ? 1'b0 : (r == 32'h0);
      e.to   = to;
      sq.push_back(e);
      gq.push_back(i);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_rsp(input int target, input int budget, input string tag);
      int t = 0;
      while (rsp_cnt < target && t < budget) begin
         tick(1);
         t++;
      end
      chk(tag, 32'(rsp_cnt), 32'(target));
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Mode 0: one-cycle done pulse; mode 1: never done; mode 2: done level-held, drops one cycle before the next result.
   always @(posedge clk) begin
      if (!mul_rst_n) begin
         m_act    <= 1'b0;
         m_cnt    <= 0;
         mul_done <= 1'b0;
      end else if (mul_start) begin
         m_act <= 1'b1;
         m_cnt <= 0;
         m_a   <= mul_a;
         m_b   <= mul_b;
         if (mock_mode != 2) mul_done <= 1'b0;
      end else if (m_act && mock_mode != 1) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt == mock_lat - 1) mul_done <= 1'b0;
         if (m_cnt == mock_lat) begin
            mul_done   <= 1'b1;
            mul_result <= mock_mul(m_a, m_b);
            mul_nar    <= (mock_mul(m_a, m_b) == 32'h8000_0000);
            mul_zero   <= (mock_mul(m_a, m_b) == 32'h0);
            m_act      <= 1'b0;
         end
      end else if (mock_mode == 0) begin
         mul_done <= 1'b0;
      end
   end

   always @(negedge clk) begin : mon
      int   g;
      exp_t e;
      if (!rst && !mul_rst_n) nrst_low = nrst_low + 1;
      if (req_ready != '0) begin
         grant_cyc = cyc;
         if (gq.size() == 0) begin
            chk("unexpected_grant", 32'(req_ready), 32'd0);
         end else begin
            g = gq.pop_front();
            chk("grant", 32'(req_ready), 32'(1) << g);
            chk("mul_start", 32'(mul_start), 32'd1);
         end
      end
      if (rsp_valid != '0) begin
         rsp_cyc = cyc;
         rsp_cnt = rsp_cnt + 1;
         if (sq.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = sq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_nar", 32'(rsp_nar), 32'(e.nar));
            chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      int base;
      int drive_cyc;
      int nbase;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = {32'h4000_0000, 32'h1234_5678, 32'h4000_0000, 32'h4000_0000};
      req_b     = {32'h8000_0000, 32'h0F0F_0F0F, 32'h0000_0000, 32'h4000_0000};
      tick(3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mul_start", 32'(mul_start), 32'd0);
      chk("rst_mul_a", mul_a, 32'd0);
      chk("rst_mul_rst_n", 32'(mul_rst_n), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      rst = 1'b0;
      tick(1);
      chk("mul_rst_n_release", 32'(mul_rst_n), 32'd1);

      // Fairness: all four held valid -> 0,1,2,3,0
      base = rsp_cnt;
      push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0); push_exp(3, 1'b0); push_exp(0, 1'b0);
      req_valid = 4'b1111;
      wait_rsp(base + 5, 100, "fair_all_count");
      req_valid = 4'b0000;
      tick(2);

      // Fairness: only 1 and 3 with ptr at 1 -> 1,3,1
      base = rsp_cnt;
      push_exp(1, 1'b0); push_exp(3, 1'b0); push_exp(1, 1'b0);
      req_valid = 4'b1010;
      wait_rsp(base + 3, 100, "fair_13_count");
      req_valid = 4'b0000;
      tick(2);

      // Single request latency
      base      = rsp_cnt;
      drive_cyc = cyc;
      push_exp(0, 1'b0);
      req_valid = 4'b0001;
      tick(1);
      req_valid = 4'b0000;
      wait_rsp(base + 1, 50, "single_count");
      chk("single_grant_lat", 32'(grant_cyc - drive_cyc), 32'd1);
      chk("single_rsp_lat", 32'(rsp_cyc - grant_cyc), 32'(mock_lat + 3));
      tick(2);

      // Level-held done: second op must wait for a fresh rising edge
      mock_mode = 2;
      mock_lat  = 4;
      base      = rsp_cnt;
      push_exp(2, 1'b0);
      req_valid = 4'b0100;
      tick(1);
      req_valid = 4'b0000;
      wait_rsp(base + 1, 50, "level1_count");
      tick(2);
      req_a[95:64] = 32'h0000_00FF;
      push_exp(2, 1'b0);
      req_valid = 4'b0100;
      tick(1);
      req_valid = 4'b0000;
      wait_rsp(base + 2, 50, "level2_count");
      chk("level2_rsp_lat", 32'(rsp_cyc - grant_cyc), 32'(mock_lat + 3));
      mock_mode = 0;
      tick(3);

      // Done edge on the last WAIT cycle beats the watchdog
      mock_lat = TO - 2;
      base     = rsp_cnt;
      nbase    = nrst_low;
      push_exp(3, 1'b0);
      req_valid = 4'b1000;
      tick(1);
      req_valid = 4'b0000;
      wait_rsp(base + 1, 60, "collide_count");
      chk("collide_rsp_lat", 32'(rsp_cyc - grant_cyc), 32'(TO + 1));
      chk("collide_no_flush", 32'(nrst_low - nbase), 32'd0);
      tick(2);

      // Watchdog: hung multiplier
      mock_mode = 1;
      mock_lat  = 3;
      base      = rsp_cnt;
      nbase     = nrst_low;
      push_exp(1, 1'b1);
      req_valid = 4'b0010;
      tick(1);
      req_valid = 4'b0000;
      wait_rsp(base + 1, 60, "wdog_count");
      chk("wdog_rsp_lat", 32'(rsp_cyc - grant_cyc), 32'(TO + 3));
      chk("wdog_rst_low", 32'(nrst_low - nbase), 32'd2);
      tick(2);

      // Reset in the middle of WAIT
      base = rsp_cnt;
      gq.push_back(2);
      req_valid = 4'b0100;
      tick(1);
      req_valid = 4'b0000;
      tick(5);
      rst = 1'b1;
      tick(2);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_mul_rst_n", 32'(mul_rst_n), 32'd0);
      chk("mid_rst_rsp_result", rsp_result, 32'd0);
      chk("mid_rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("mid_rst_mul_a", mul_a, 32'd0);
      mock_mode = 0;
      rst = 1'b0;
      tick(1);
      chk("mid_rst_release", 32'(mul_rst_n), 32'd1);
      tick(25);
      chk("mid_rst_no_rsp", 32'(rsp_cnt), 32'(base));
      push_exp(0, 1'b0);
      req_valid = 4'b1111;
      tick(1);
      req_valid = 4'b0000;
      wait_rsp(base + 1, 50, "ptr_reset_count");
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
